// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types, pattern/state enums and bar colours for the pixel stream generator.
package pixel_pkg;
  typedef logic [11:0] rgb444_t;
  typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_RAMP} pattern_e;
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_GAP} gen_state_e;
  localparam rgb444_t BAR_COLOURS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pixel_stream_gen_pattern_lut.sv
// pattern_lut: combinational pixel colour for a coordinate; bars lookup only with PIXEL_GEN_BARS_EN.
module pattern_lut
  import pixel_pkg::*;
#(
  parameter int WIDTH = 320,
  parameter int XW    = 9,
  parameter int YW    = 8
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  pattern_e      i_pattern,
  input  rgb444_t       i_colour,
  output rgb444_t       o_pixel
);
  logic [31:0] w_xe;
  logic [3:0]  w_ramp;
  logic        w_chk;
  rgb444_t     w_bars;
  assign w_xe   = 32'(i_x);
  assign w_ramp = 4'((w_xe * 16) / 32'(WIDTH));
  assign w_chk  = 1'(w_xe >> 4) ^ 1'(32'(i_y) >> 4);
`ifdef PIXEL_GEN_BARS_EN
  logic [2:0] w_bar;
  assign w_bar  = 3'((w_xe * 8) / 32'(WIDTH));
  assign w_bars = BAR_COLOURS[w_bar];
`else
  assign w_bars = i_colour;
`endif
  assign o_pixel = i_pattern == PAT_CHECKER ? (w_chk ? 12'h000 : i_colour) :
                   i_pattern == PAT_RAMP    ? {3{w_ramp}} :
                   i_pattern == PAT_BARS    ? w_bars : i_colour;
endmodule

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: frame FSM with valid/ready handshake and registered pixel outputs.
// Optional macro PIXEL_GEN_BARS_EN enables the colour-bar pattern.
module pixel_stream_gen
  import pixel_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int GAP    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_colour,
  input  logic        ready,
  output logic [11:0] pixel,
  output logic        valid,
  output logic        sop,
  output logic        eop,
  output logic        frame_done
);
  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);
  gen_state_e    r_state;
  logic [XW-1:0] r_x, w_nx, w_lx;
  logic [YW-1:0] r_y, w_ny, w_ly;
  logic [7:0]    r_gap;
  pattern_e      r_pat, w_lpat;
  rgb444_t       r_col, w_lcol, w_lpix;
  logic          w_last_x, w_last, w_streaming, w_gap_end, w_start;
  assign w_last_x    = r_x == XW'(WIDTH - 1);
  assign w_last      = w_last_x && r_y == YW'(HEIGHT - 1);
  assign w_nx        = w_last_x ? '0 : r_x + 1'b1;
  assign w_ny        = w_last_x ? r_y + 1'b1 : r_y;
  assign w_streaming = r_state == ST_STREAM;
  assign w_gap_end   = r_state == ST_GAP && r_gap == 8'(GAP - 1);
  assign w_start     = enable && (r_state == ST_IDLE || w_gap_end);
  // The LUT looks one pixel ahead so pixel can be registered alongside x/y.
  assign w_lx   = w_streaming ? w_nx : '0;
  assign w_ly   = w_streaming ? w_ny : '0;
  assign w_lpat = w_streaming ? r_pat : pattern_e'(pattern_sel);
  assign w_lcol = w_streaming ? r_col : solid_colour;
  pattern_lut #(.WIDTH(WIDTH), .XW(XW), .YW(YW)) u_lut (
    .i_x      (w_lx),
    .i_y      (w_ly),
    .i_pattern(w_lpat),
    .i_colour (w_lcol),
    .o_pixel  (w_lpix)
  );
  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_gap   <= '0;
      r_pat   <= PAT_SOLID;
      r_col   <= '0;
      valid   <= 1'b0;
      sop     <= 1'b0;
      eop     <= 1'b0;
      pixel   <= '0;
    end else if (w_start) begin
      r_state <= ST_STREAM;
      r_x     <= '0;
      r_y     <= '0;
      r_gap   <= '0;
      r_pat   <= pattern_e'(pattern_sel);
      r_col   <= solid_colour;
      valid   <= 1'b1;
      sop     <= 1'b1;
      eop     <= WIDTH == 1 && HEIGHT == 1;
      pixel   <= w_lpix;
    end else if (r_state == ST_GAP) begin
      r_gap   <= r_gap + 1'b1;
      r_state <= w_gap_end ? ST_IDLE : ST_GAP;
    end else if (w_streaming && ready) begin
      if (w_last) begin
        r_state    <= ST_GAP;
        r_gap      <= '0;
        valid      <= 1'b0;
        sop        <= 1'b0;
        eop        <= 1'b0;
        pixel      <= '0;
        frame_done <= 1'b1;
      end else begin
        r_x   <= w_nx;
        r_y   <= w_ny;
        sop   <= 1'b0;
        eop   <= w_nx == XW'(WIDTH - 1) && w_ny == YW'(HEIGHT - 1);
        pixel <= w_lpix;
      end
    end
  end
endmodule

// File: doc/pixel_stream_gen.md
PIXEL_STREAM_GEN -- requirements
Module: pixel_stream_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 320, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 240, lines per frame.
REQ-003 SHALL have parameter GAP, default 16, idle cycles between frames (legal range 1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  start and continue frame generation while high.
REQ-007 SHALL have port pattern_sel  input  2  0 = solid, 1 = colour bars, 2 = checkerboard, 3 = grey ramp.
REQ-008 SHALL have port solid_colour  input  12  RGB444 colour {R[11:8],G[7:4],B[3:0]} used for solid and checker modes.
REQ-009 SHALL have port ready  input  1  downstream accepts the current pixel.
REQ-010 SHALL have port pixel  output  12  RGB444 pixel data.
REQ-011 SHALL have port valid  output  1  pixel, sop and eop are meaningful.
REQ-012 SHALL have port sop  output  1  high with the first pixel of a frame.
REQ-013 SHALL have port eop  output  1  high with the last pixel of a frame.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse on the cycle after the eop transfer.

Function
REQ-015 SHALL implement an FSM with states IDLE, STREAM and GAP.
REQ-016 IDLE -> STREAM SHALL occur on the clock edge where enable = 1; valid SHALL rise on the next cycle with x = 0, y = 0.
REQ-017 A transfer SHALL occur only on a cycle with valid = 1 and ready = 1; without a transfer, pixel, sop and eop SHALL hold stable.
REQ-018 Counter x SHALL advance 0..WIDTH-1 per transfer and wrap to 0 while incrementing y (0..HEIGHT-1); counter widths SHALL be $clog2 of the parameter, with a minimum of 1.
REQ-019 sop SHALL equal valid && x == 0 && y == 0.
REQ-020 eop SHALL equal valid && x == WIDTH-1 && y == HEIGHT-1.
REQ-021 When WIDTH = HEIGHT = 1, sop and eop SHALL be high on the same pixel.
REQ-022 The eop transfer SHALL move the FSM to GAP; valid SHALL be 0 for exactly GAP cycles.
REQ-023 After GAP, the FSM SHALL go to STREAM if enable = 1, otherwise to IDLE.
REQ-024 Deasserting enable mid-frame SHALL NOT truncate the frame: the current frame completes, then GAP, then IDLE.
REQ-025 pattern_sel and solid_colour SHALL be latched on entry to STREAM and held constant for the whole frame.
REQ-026 Solid mode SHALL output pixel = latched solid_colour.
REQ-027 Bars mode SHALL output bar index b = (x*8)/WIDTH, computed with integer floor.
REQ-028 Bar colours for b = 0..7 SHALL be FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-029 Checker mode SHALL output solid_colour when x[4] ^ y[4] = 0, else 000.
REQ-030 Ramp mode SHALL output R = G = B = (x*16)/WIDTH.
REQ-031 pixel SHALL be 000 whenever valid = 0.

Reset
REQ-032 reset SHALL take priority over all other inputs.
REQ-033 On the next edge with reset = 1, the FSM SHALL go to IDLE with x = y = 0 and the gap counter = 0.
REQ-034 On that edge, valid, sop, eop, frame_done and pixel SHALL all be 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no eop.
REQ-036 After reset, the next frame SHALL start with sop.

Configuration
REQ-037 Macro PIXEL_GEN_BARS_EN defined SHALL compile in the bars lookup, with pattern_sel = 1 behaving per REQ-027/028.
REQ-038 Without PIXEL_GEN_BARS_EN, the bars logic SHALL be absent and pattern_sel = 1 SHALL behave as solid mode.

Structure
REQ-039 Shared package pixel_pkg SHALL hold:
- typedef rgb444_t (12-bit);
- enum pattern_e {PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_RAMP};
- the bar-colour constant array;
- state enum gen_state_e.
REQ-040 Sub-module pattern_lut (combinational: x, y, pattern, colour -> pixel) SHALL contain all pattern arithmetic; pixel_stream_gen SHALL own the FSM and counters.

Verification
REQ-041 WIDTH=8, HEIGHT=2, GAP=3, solid 123, ready = 1, enable pulsed 1 cycle: SHALL produce 16 pixels of 123, sop on pixel 0, eop on pixel 15, frame_done 1 cycle later, then IDLE.
REQ-042 Same parameters, enable held, ready toggled 1/0 every cycle: SHALL show pixel and sop stable while stalled, exactly 16 transfers, 3 idle cycles, then a second sop.
REQ-043 WIDTH=8, bars, ready = 1: SHALL produce pixel sequence FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000 per line; without PIXEL_GEN_BARS_EN, all pixels SHALL equal solid_colour.
REQ-044 Reset asserted on pixel 5: SHALL give valid = 0 the next cycle with no eop; with enable = 1, the following frame SHALL begin with sop and pixel x = 0.
REQ-045 WIDTH=1, HEIGHT=1: SHALL produce one pixel per frame with sop = eop = 1, and GAP idle cycles between frames.
REQ-046 pattern_sel changed from 0 to 2 mid-frame: current frame SHALL stay solid; the next frame SHALL be checker (WIDTH=32: x = 0..15 solid_colour, x = 16..31 000 on line 0).
